// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
// Holds default sizes, the response-register state encoding,
// and helpers for deriving id and product widths.
package mult_arb_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int NREQ_DEF   = 4;
    localparam int CNTW_DEF   = 16;
    localparam int PROD_W_DEF = 2 * WIDTH_DEF;

    // The response register is either empty or holding one product.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Width of a requester index.
    // This is clamped to at least one bit so that a degenerate count still yields a legal vector.
    function automatic int idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection, purely combinational.
// Ports:
//   req          - pending request bits, one per requester
//   ptr          - index where the search starts (highest priority this cycle)
//   any          - at least one request is pending
//   grant_idx    - index of the first pending request at or after ptr, wrapping
//   grant_onehot - the same grant as a one-hot vector
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  grant_idx,
    output logic [NREQ-1:0] grant_onehot
);

    int w_idx;

    // Walk the requesters starting at ptr and take the first one that is set.
    // The index wraps by subtraction, so NREQ does not have to be a power of two.
    always_comb begin
        any          = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        w_idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!any && req[w_idx]) begin
                any                 = 1'b1;
                grant_idx           = IDW'(w_idx);
                grant_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one unsigned WIDTH x WIDTH multiplier among NREQ requesters.
// Each cycle, at most one request is granted in round-robin order.
// Its product is registered and presented on a single valid/ready response channel.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   req_valid     - per-requester operands pending
//   req_a, req_b  - packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready     - one-hot grant; transfer when req_valid[i] & req_ready[i]
//   rsp_valid     - result register holds a product
//   rsp_ready     - consumer takes the result
//   rsp_id        - requester that owns the result
//   rsp_product   - registered product
//   op_count      - accepted-request counter, wraps
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int CNTW  = CNTW_DEF,
    localparam int IDW  = idw(NREQ),
    localparam int PW   = 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [PW-1:0]     rsp_product,
    output logic [CNTW-1:0]   op_count
);

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [PW-1:0]   r_product;
    logic [CNTW-1:0] r_count;

    logic            w_any;
    logic [IDW-1:0]  w_grant_idx;
    logic [NREQ-1:0] w_grant_onehot;
    logic            w_can_issue;
    logic            w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [PW-1:0]   w_product;
    logic [IDW-1:0]  w_ptr_next;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req          (req_valid),
        .ptr          (r_ptr),
        .any          (w_any),
        .grant_idx    (w_grant_idx),
        .grant_onehot (w_grant_onehot)
    );

    // A new product may be loaded when the register is empty or is draining this cycle.
    // Draining and refilling in the same cycle avoids a bubble.
    assign w_can_issue = (r_state == ST_EMPTY) || rsp_ready;
    assign w_accept    = w_can_issue && w_any;

    // The grant is gated off during reset, so nothing is handed out while the result is discarded.
    assign req_ready = (w_accept && !rst) ? w_grant_onehot : '0;

    assign w_a       = req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_b       = req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_product = PW'(w_a) * PW'(w_b);

    assign w_ptr_next = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // Response FSM plus the result, id, pointer and counter registers.
    // The pointer only advances on a grant, so idle cycles do not disturb the fairness order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_ptr     <= '0;
            r_id      <= '0;
            r_product <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_state <= ST_FULL;
                ST_FULL:  if (!w_accept && rsp_ready) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
            if (w_accept) begin
                r_product <= w_product;
                r_id      <= w_grant_idx;
                r_ptr     <= w_ptr_next;
                r_count   <= r_count + 1'b1;
            end
        end
    end

    assign rsp_valid   = (r_state == ST_FULL);
    assign rsp_id      = r_id;
    assign rsp_product = r_product;
    assign op_count    = r_count;

endmodule
